// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// controller states and the iteration-counter sizing.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // The counter must hold the value WIDTH itself.
  function automatic int muldiv_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore result signs.
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit: WIDTH cycles of shift-add or
// restoring subtract-shift on one shared accumulator, then a sign fix-up cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);

  localparam int CNT_W = muldiv_cnt_w(WIDTH);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dbz_q, dbz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_rem, div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 div0;
  logic [WIDTH-1:0]     res_hi, res_lo;

  assign a_neg = op_is_signed(Op) & A[WIDTH-1];
  assign b_neg = op_is_signed(Op) & B[WIDTH-1];

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (.value(A), .negate(a_neg), .result(a_mag));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (.value(B), .negate(b_neg), .result(b_mag));

  // Multiply step: conditionally add the multiplicand to the high half, shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide step: shift left, trial-subtract the divisor, keep it if non-negative.
  assign div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_rem - {1'b0, opb_q};
  assign div_next = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_prod (.value(acc_q), .negate(neg_lo_q), .result(prod_fix));
  muldiv_abs #(.WIDTH(WIDTH)) u_fix_quo (.value(acc_q[WIDTH-1:0]), .negate(neg_lo_q), .result(quo_fix));
  muldiv_abs #(.WIDTH(WIDTH)) u_fix_rem (.value(acc_q[2*WIDTH-1:WIDTH]), .negate(neg_hi_q), .result(rem_fix));

  // With a zero divisor the restoring loop leaves |A| in the remainder, so the
  // sign-fixed remainder is A itself; only the quotient needs overriding.
  assign div0   = is_div_q & (opb_q == '0);
  assign res_hi = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo = is_div_q ? (div0 ? DIV0_LO : quo_fix) : prod_fix[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    if (Flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_d  = ST_RUN;
            cnt_d    = CNT_W'(WIDTH);
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            opb_d    = b_mag;
            is_div_d = op_is_div(Op);
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
          end
        end
        ST_RUN: begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d = ST_DONE;
          hi_d    = res_hi;
          lo_d    = res_lo;
          dbz_d   = div0;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model with a
// cycle-count timing model, directed literal cases and randomized traffic.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         Clk, Rst, Start, Flush, Busy, Done, DivByZero;
  logic [1:0]   Op;
  logic [W-1:0] A, B, Hi, Lo;

  int checks = 0;
  int failures = 0;
  bit check_en = 0;
  int dut_dones = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .Flush(Flush),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {hi, lo, div_by_zero}.
  function automatic logic [2*W:0] model_res(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    logic [W-1:0] hi, lo;
    logic dz;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          hi = a; lo = '1; dz = 1'b1;
        end else if (op == 2'b10) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
    endcase
    return {hi, lo, dz};
  endfunction

  // Timing model: m_cnt counts cycles since acceptance; 0 means idle.
  int           m_cnt = 0;
  int           m_completions = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0, pend_hi = '0, pend_lo = '0;
  logic         exp_dz = 1'b0, pend_dz = 1'b0;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_cnt  <= 0;
      exp_hi <= '0;
      exp_lo <= '0;
      exp_dz <= 1'b0;
    end else if (m_cnt == 0) begin
      if (Start && !Flush) begin
        m_cnt <= 1;
        {pend_hi, pend_lo, pend_dz} <= model_res(Op, A, B);
      end
    end else if (Flush) begin
      m_cnt <= 0;
    end else if (m_cnt == W + 1) begin
      m_cnt  <= W + 2;
      exp_hi <= pend_hi;
      exp_lo <= pend_lo;
      exp_dz <= pend_dz;
      m_completions <= m_completions + 1;
    end else if (m_cnt == W + 2) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  initial forever begin
    @(negedge Clk);
    if (check_en) begin
      chk("busy", {63'b0, Busy}, {63'b0, m_cnt != 0});
      chk("done", {63'b0, Done}, {63'b0, m_cnt == W + 2});
      chk("hi", {32'b0, Hi}, {32'b0, exp_hi});
      chk("lo", {32'b0, Lo}, {32'b0, exp_lo});
      chk("dbz", {63'b0, DivByZero}, {63'b0, exp_dz});
      if (Done) dut_dones++;
    end
  end

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 32'h1;
      2: v = '1;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = W'($urandom_range(0, 15));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Drives a request at the current falling edge and waits for Done.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
    int n;
    bit seen;
    Op = op; A = a; B = b; Start = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 60) begin
      @(negedge Clk);
      n++;
      Start = 1'b0;
      if (Done) seen = 1;
    end
    chk({tag, "_latency"}, 64'(n), 64'(W + 2));
    @(negedge Clk);
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] hi, input logic [W-1:0] lo,
                         input logic dz);
    chk({tag, "_hi"}, {32'b0, Hi}, {32'b0, hi});
    chk({tag, "_lo"}, {32'b0, Lo}, {32'b0, lo});
    chk({tag, "_dbz"}, {63'b0, DivByZero}, {63'b0, dz});
  endtask

  initial begin
    logic [2*W:0] r;
    int n, nd, first_n, second_n;

    Rst = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 2'b00; A = '0; B = '0;

    r = model_res(2'b01, 32'hFFFF_FFFD, 32'd5);
    chk("model_mult", r[2*W:1], 64'hFFFF_FFFF_FFFF_FFF1);
    r = model_res(2'b11, 32'hFFFF_FFF9, 32'd2);
    chk("model_div", r[2*W:1], 64'hFFFF_FFFF_FFFF_FFFD);
    r = model_res(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("model_divmin", r, 65'h0_0000_0001_0000_0000);

    repeat (3) @(negedge Clk);
    chk_res("reset", '0, '0, 1'b0);
    chk("reset_busy", {63'b0, Busy}, 64'd0);
    chk("reset_done", {63'b0, Done}, 64'd0);
    check_en = 1;

    Rst = 1'b1;
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk_res("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, "mult_neg");
    chk_res("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_neg");
    chk_res("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op(2'b10, 32'd7, 32'd0, "divu_zero");
    chk_res("divu_zero", 32'd7, 32'hFFFF_FFFF, 1'b1);
    do_op(2'b10, 32'd9, 32'd4, "divu_9_4");
    chk_res("divu_9_4", 32'd1, 32'd2, 1'b0);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
    chk_res("div_min", 32'd0, 32'h8000_0000, 1'b0);

    // Flush at RUN cycle 10.
    Op = 2'b00; A = 32'd3; B = 32'd3; Start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    chk("flush_busy", {63'b0, Busy}, 64'd0);
    nd = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge Clk);
      if (Done) nd++;
    end
    chk("flush_no_done", 64'(nd), 64'd0);
    chk_res("flush_keep", 32'd0, 32'h8000_0000, 1'b0);

    // Flush wins over Start in IDLE.
    Start = 1'b1; Flush = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
    chk("flush_start_busy", {63'b0, Busy}, 64'd0);
    @(negedge Clk);

    // Start held high: back-to-back issue, busy-time Start ignored.
    Op = 2'b10; A = 32'd100; B = 32'd7; Start = 1'b1;
    nd = 0; first_n = 0; second_n = 0;
    for (n = 1; n <= 2 * W + 6; n++) begin
      @(negedge Clk);
      if (Done) begin
        nd++;
        if (nd == 1) first_n = n; else second_n = n;
      end
    end
    Start = 1'b0;
    chk("b2b_count", 64'(nd), 64'd2);
    chk("b2b_first", 64'(first_n), 64'(W + 2));
    chk("b2b_interval", 64'(second_n - first_n), 64'(W + 3));
    chk_res("b2b", 32'd2, 32'd14, 1'b0);
    @(negedge Clk);

    // Reset in the middle of RUN.
    Op = 2'b00; A = 32'd5; B = 32'd5; Start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    #2 Rst = 1'b0;
    #1;
    chk_res("async_rst", '0, '0, 1'b0);
    chk("async_rst_busy", {63'b0, Busy}, 64'd0);
    chk("async_rst_done", {63'b0, Done}, 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    do_op(2'b00, 32'd6, 32'd7, "after_rst");
    chk_res("after_rst", 32'd0, 32'd42, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 4000; i++) begin
      Start = ($urandom_range(0, 3) != 0);
      Flush = ($urandom_range(0, 199) == 0);
      Op    = 2'($urandom_range(0, 3));
      A     = pick();
      B     = ($urandom_range(0, 9) == 0) ? '0 : pick();
      @(negedge Clk);
    end
    Start = 1'b0; Flush = 1'b0;
    repeat (W + 5) @(negedge Clk);
    chk("done_total", 64'(dut_dones), 64'(m_completions));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
